// File: rtl/alu_result_serializer.sv
// alu_result_serializer: buffers ALU results in a small FIFO and streams each one to
// the UART TX path, LSB first. Define ALU_SER_HDR_EN to prefix every frame with HDR.
module alu_result_serializer #(
  parameter int         WIDTH = 16,
  parameter int         DEPTH = 4,
  parameter logic [7:0] HDR   = 8'hA5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_alu_valid,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic             i_tx_ready,
  output logic             o_tx_valid,
  output logic [7:0]       o_tx_data,
  output logic             o_full,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
`ifdef ALU_SER_HDR_EN
  localparam int NBYTES = WIDTH / 8 + 1;
`else
  localparam int NBYTES = WIDTH / 8;
`endif
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Serializer state; kept as a named enum register so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [WIDTH-1:0]  shift_reg;
  logic [BCNT_W-1:0] byte_cnt;

  logic fifo_empty;
  logic fifo_full;
  logic xfer;
  logic last_byte;
  logic pop;
  logic push;
  logic adv;
  logic shift_now;
  logic [7:0] cur_byte;

  // TX handshake: o_tx_valid/o_tx_data are held stable from the moment valid
  // rises until a cycle with i_tx_ready=1; a byte moves exactly on valid & ready.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign xfer       = (state == SEND) & i_tx_ready;
  assign last_byte  = (byte_cnt == LAST_BYTE);
  assign o_tx_valid = (state == SEND);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    adv        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!last_byte) begin
            adv = 1'b1;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A full FIFO still accepts when the head leaves on the same edge.
  assign push = i_alu_valid & (~fifo_full | pop);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

`ifdef ALU_SER_HDR_EN
  // The header is byte 0 of the frame and never occupies the result register.
  assign cur_byte  = (byte_cnt == '0) ? HDR : shift_reg[7:0];
  assign shift_now = adv & (byte_cnt != '0);
`else
  logic unused_hdr;
  assign unused_hdr = ^HDR;
  assign cur_byte   = shift_reg[7:0];
  assign shift_now  = adv;
`endif

  assign o_tx_data = o_tx_valid ? cur_byte : 8'h00;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_alu_out;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      shift_reg  <= '0;
      byte_cnt   <= '0;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        shift_reg <= mem[rd_ptr];
        byte_cnt  <= '0;
      end else if (adv) begin
        byte_cnt <= byte_cnt + BCNT_W'(1);
        if (shift_now) begin
          shift_reg <= shift_reg >> 8;
        end
      end
      count <= count_next;
      if (i_alu_valid & ~push) begin
        o_overflow <= 1'b1;
      end
      o_full <= (count_next == FULL_CNT);
      o_busy <= (state_next != IDLE) | (count_next != '0);
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer: directed scenarios plus random
// traffic scored against a result-level byte-stream model.
`timescale 1ns/1ps
module tb_alu_result_serializer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
`ifdef ALU_SER_HDR_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam int NB = WIDTH / 8 + HDR_BYTES;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_alu_valid = 1'b0;
  logic [WIDTH-1:0] i_alu_out = '0;
  logic             i_tx_ready = 1'b0;
  logic             o_tx_valid;
  logic [7:0]       o_tx_data;
  logic             o_full;
  logic             o_overflow;
  logic             o_busy;

  alu_result_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HDR(8'hA5)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_alu_valid (i_alu_valid),
    .i_alu_out   (i_alu_out),
    .i_tx_ready  (i_tx_ready),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .o_full      (o_full),
    .o_overflow  (o_overflow),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted results expand into the byte stream they must
  // produce; a result is dropped when DEPTH+1 results are already held and no
  // frame finishes on that edge.
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         n_acc;
  int         n_obs;
  logic       ovf_model;

  task automatic model_clear();
    exp_q.delete();
    obs_q.delete();
    n_acc     = 0;
    n_obs     = 0;
    ovf_model = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    i_alu_valid = 1'b0;
    i_alu_out   = '0;
    i_tx_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: observe at the falling edge, update the model, then step past the rising edge.
  task automatic cycle();
    bit last;
    int held;
    @(negedge clk);
    last = 1'b0;
    held = n_acc - n_obs / NB;
    if (o_tx_valid && i_tx_ready) begin
      obs_q.push_back(o_tx_data);
      n_obs++;
      last = ((n_obs % NB) == 0);
    end
    if (i_alu_valid) begin
      if (held == DEPTH + 1 && !last) begin
        ovf_model = 1'b1;
      end else begin
        n_acc++;
        if (HDR_BYTES != 0) exp_q.push_back(8'hA5);
        for (int b = 0; b < WIDTH / 8; b++) exp_q.push_back(i_alu_out[8*b +: 8]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] v);
    i_alu_valid = 1'b1;
    i_alu_out   = v;
    cycle();
    i_alu_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    i_alu_valid = 1'b0;
    i_tx_ready  = 1'b1;
    while ((obs_q.size() < exp_q.size() || o_busy) && k < 500) begin
      cycle();
      k++;
    end
  endtask

  function automatic int stream_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] obs_at(input int i);
    return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'h00;
  endfunction

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_tx_valid); end
    n_tests++;
    if (o_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_tx_data); end
    n_tests++;
    if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", o_full); end
    n_tests++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
    n_tests++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_single();
    int d;
    do_reset();
    i_tx_ready = 1'b1;
    push_one(16'h1234);
    n_tests++;
    if (o_tx_valid !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL single_capture: valid=%b busy=%b want valid=0 busy=1", o_tx_valid, o_busy);
    end
    cycle();
    n_tests++;
    if (o_tx_valid !== 1'b1 || o_tx_data !== (HDR_BYTES != 0 ? 8'hA5 : 8'h34)) begin
      n_fail++; $display("FAIL single_latency: valid=%b data=%h", o_tx_valid, o_tx_data);
    end
    cycle();
    n_tests++;
    if (o_tx_valid !== 1'b1 || o_tx_data !== (HDR_BYTES != 0 ? 8'h34 : 8'h12)) begin
      n_fail++; $display("FAIL single_second: valid=%b data=%h", o_tx_valid, o_tx_data);
    end
    drain();
    d = stream_diff();
    n_tests++;
    if (d != -1) begin
      n_fail++; $display("FAIL single_stream: idx %0d got %h (n=%0d) want %h (n=%0d)", d, obs_at(d), obs_q.size(), exp_at(d), exp_q.size());
    end
    n_tests++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b want 0", o_busy); end
  endtask

  task automatic test_hold();
    int d;
    do_reset();
    i_tx_ready = 1'b0;
    push_one(16'h1234);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== (HDR_BYTES != 0 ? 8'hA5 : 8'h34)) begin
        n_fail++; $display("FAIL hold_stable[%0d]: valid=%b data=%h", i, o_tx_valid, o_tx_data);
      end
    end
    drain();
    d = stream_diff();
    n_tests++;
    if (d != -1) begin
      n_fail++; $display("FAIL hold_stream: idx %0d got %h (n=%0d) want %h (n=%0d)", d, obs_at(d), obs_q.size(), exp_at(d), exp_q.size());
    end
  endtask

  task automatic test_overflow();
    int d;
    do_reset();
    i_tx_ready = 1'b0;
    for (int v = 1; v <= 6; v++) push_one(WIDTH'(v));
    n_tests++;
    if (o_overflow !== 1'b1 || o_full !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flags: overflow=%b full=%b want 1 1", o_overflow, o_full);
    end
    drain();
    d = stream_diff();
    n_tests++;
    if (d != -1) begin
      n_fail++; $display("FAIL ovf_stream: idx %0d got %h (n=%0d) want %h (n=%0d)", d, obs_at(d), obs_q.size(), exp_at(d), exp_q.size());
    end
    n_tests++;
    if (o_overflow !== 1'b1 || o_full !== 1'b0) begin
      n_fail++; $display("FAIL ovf_sticky: overflow=%b full=%b want 1 0", o_overflow, o_full);
    end
  endtask

  task automatic test_full_pop();
    int d;
    do_reset();
    i_tx_ready = 1'b0;
    for (int v = 1; v <= DEPTH + 1; v++) push_one(WIDTH'(16'h0101 * v));
    n_tests++;
    if (o_full !== 1'b1) begin n_fail++; $display("FAIL fullpop_full: got %b want 1", o_full); end
    i_tx_ready = 1'b1;
    repeat (NB - 1) cycle();
    push_one(16'h00AA);
    n_tests++;
    if (o_overflow !== 1'b0 || o_full !== 1'b1) begin
      n_fail++; $display("FAIL fullpop_nodrop: overflow=%b full=%b want 0 1", o_overflow, o_full);
    end
    drain();
    d = stream_diff();
    n_tests++;
    if (d != -1) begin
      n_fail++; $display("FAIL fullpop_stream: idx %0d got %h (n=%0d) want %h (n=%0d)", d, obs_at(d), obs_q.size(), exp_at(d), exp_q.size());
    end
    n_tests++;
    if (obs_at(obs_q.size() - 2) !== 8'hAA || obs_at(obs_q.size() - 1) !== 8'h00) begin
      n_fail++; $display("FAIL fullpop_tail: got %h %h want aa 00", obs_at(obs_q.size() - 2), obs_at(obs_q.size() - 1));
    end
  endtask

  task automatic test_reset_mid();
    int d;
    do_reset();
    i_tx_ready = 1'b0;
    push_one(16'h1234);
    cycle();
    i_tx_ready = 1'b1;
    repeat (NB - 1) cycle();
    i_tx_ready = 1'b0;
    n_tests++;
    if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h12) begin
      n_fail++; $display("FAIL rstmid_pending: valid=%b data=%h want 1 12", o_tx_valid, o_tx_data);
    end
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({o_tx_valid, o_tx_data, o_full, o_overflow, o_busy} !== 12'h000) begin
      n_fail++; $display("FAIL rstmid_outputs: valid=%b data=%h full=%b ovf=%b busy=%b want all 0",
                         o_tx_valid, o_tx_data, o_full, o_overflow, o_busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    i_tx_ready = 1'b1;
    push_one(16'h1234);
    drain();
    d = stream_diff();
    n_tests++;
    if (d != -1) begin
      n_fail++; $display("FAIL rstmid_stream: idx %0d got %h (n=%0d) want %h (n=%0d)", d, obs_at(d), obs_q.size(), exp_at(d), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int d;
    int gaps;
    int k;
    bit seen;
    do_reset();
    i_tx_ready = 1'b1;
    push_one(16'hBEEF);
    push_one(16'hCAFE);
    gaps = 0;
    seen = 1'b0;
    k    = 0;
    while (obs_q.size() < 2 * NB && k < 40) begin
      if (o_tx_valid) seen = 1'b1;
      else if (seen) gaps++;
      cycle();
      k++;
    end
    n_tests++;
    if (gaps !== 0 || obs_q.size() != 2 * NB) begin
      n_fail++; $display("FAIL b2b_gap: gaps=%0d bytes=%0d want 0 %0d", gaps, obs_q.size(), 2 * NB);
    end
    drain();
    d = stream_diff();
    n_tests++;
    if (d != -1) begin
      n_fail++; $display("FAIL b2b_stream: idx %0d got %h (n=%0d) want %h (n=%0d)", d, obs_at(d), obs_q.size(), exp_at(d), exp_q.size());
    end
  endtask

  task automatic test_random();
    int d;
    int rdy_pct;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rdy_pct     = (i < 400) ? 20 : 85;
      i_alu_valid = ($urandom_range(0, 99) < 45);
      i_alu_out   = WIDTH'($urandom);
      i_tx_ready  = ($urandom_range(0, 99) < rdy_pct);
      cycle();
    end
    drain();
    d = stream_diff();
    n_tests++;
    if (d != -1) begin
      n_fail++; $display("FAIL rand_stream: idx %0d got %h (n=%0d) want %h (n=%0d)", d, obs_at(d), obs_q.size(), exp_at(d), exp_q.size());
    end
    n_tests++;
    if (o_overflow !== ovf_model) begin
      n_fail++; $display("FAIL rand_overflow: got %b want %b", o_overflow, ovf_model);
    end
    n_tests++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle: busy=%b want 0", o_busy); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
